data_memory_responder: RTL and testbench

Responder end of the CPU data-memory request interface. It accepts load/store requests from the MEM stage and services them from an internal word-organised RAM with a configurable number of wait states. While a request is pending it drives dataMemorySuccess low, which freezes the pipeline through the freeze unit. Loads return byte/half/word data with sign or zero extension.

---
 rtl/data_memory_responder.sv | 177 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder side of the CPU data-memory request interface. A load or store
// from the MEM stage is accepted in IDLE, held for WAIT_STATES cycles in
// WAIT, and completed in a single DONE cycle. While a request is
// outstanding, dataMemorySuccess stays low so that the freeze unit stalls
// the pipeline. Storage is an internal RAM organised as 32-bit words.
//
// Parameters:
//   ADDRESS_WIDTH  word-index bits; RAM depth is 2**ADDRESS_WIDTH words
//   WAIT_STATES    extra cycles between acceptance and completion (0 allowed)
//
// Ports:
//   clk                     clock
//   rst                     synchronous, active-high reset
//   dataMemoryWriteEnable   store request
//   dataMemoryReadEnable    load request
//   dataMemoryAddress       byte address (higher bits alias)
//   dataMemoryDataIn        store data (always a full word)
//   dataMemoryReadByte      load is byte-wide (takes priority over half)
//   dataMemoryReadHalf      load is half-wide
//   dataMemoryReadUnsigned  zero-extend instead of sign-extend
//   dataMemoryDataOut       registered load result, held until the next load
//   dataMemorySuccess       high when idle or completing this cycle
module data_memory_responder #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int WAIT_STATES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dataMemoryWriteEnable,
    input  logic        dataMemoryReadEnable,
    input  logic [31:0] dataMemoryAddress,
    input  logic [31:0] dataMemoryDataIn,
    input  logic        dataMemoryReadByte,
    input  logic        dataMemoryReadHalf,
    input  logic        dataMemoryReadUnsigned,
    output logic [31:0] dataMemoryDataOut,
    output logic        dataMemorySuccess
);

    localparam int DEPTH       = 1 << ADDRESS_WIDTH;
    localparam int COUNT_WIDTH = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [COUNT_WIDTH-1:0]   count;
    logic [COUNT_WIDTH-1:0]   count_next;

    logic [31:0]              mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] req_index;
    logic [1:0]               req_offset;
    logic [31:0]              req_data;
    logic                     req_write;
    logic                     req_byte;
    logic                     req_half;
    logic                     req_unsigned;

    logic                     request;
    logic [ADDRESS_WIDTH-1:0] sel_index;
    logic [1:0]               sel_offset;
    logic                     sel_write;
    logic                     sel_byte;
    logic                     sel_half;
    logic                     sel_unsigned;
    logic [31:0]              read_word;
    logic [7:0]               byte_lane;
    logic [15:0]              half_lane;
    logic [31:0]              load_value;
    logic                     entering_done;
    logic                     unused_address_bits;

    assign request = dataMemoryReadEnable | dataMemoryWriteEnable;

    // Bits above the word index are deliberately ignored so the RAM aliases.
    assign unused_address_bits = ^dataMemoryAddress[31:ADDRESS_WIDTH+2];

    // With zero wait states the request goes straight from IDLE to DONE, so
    // the load has to be evaluated from the live inputs before they have
    // been latched; in every other state the latched request is used.
    assign sel_index    = (state == IDLE) ? dataMemoryAddress[ADDRESS_WIDTH+1:2] : req_index;
    assign sel_offset   = (state == IDLE) ? dataMemoryAddress[1:0] : req_offset;
    assign sel_write    = (state == IDLE) ? dataMemoryWriteEnable  : req_write;
    assign sel_byte     = (state == IDLE) ? dataMemoryReadByte     : req_byte;
    assign sel_half     = (state == IDLE) ? dataMemoryReadHalf     : req_half;
    assign sel_unsigned = (state == IDLE) ? dataMemoryReadUnsigned : req_unsigned;

    assign read_word     = mem[sel_index];
    assign entering_done = (state != DONE) && (state_next == DONE);

    // Lane extraction and extension. A byte request wins over a half request.
    always_comb begin
        byte_lane  = read_word[{sel_offset, 3'b000} +: 8];
        half_lane  = sel_offset[1] ? read_word[31:16] : read_word[15:0];
        load_value = read_word;
        if (sel_byte) begin
            load_value = sel_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        end else if (sel_half) begin
            load_value = sel_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        end
    end

    // Next-state logic and the handshake. Success drops combinationally in
    // the cycle a request appears and is forced high while reset is held.
    always_comb begin
        state_next        = state;
        count_next        = count;
        dataMemorySuccess = 1'b1;
        case (state)
            IDLE: begin
                dataMemorySuccess = !request;
                count_next        = '0;
                if (request) begin
                    if (WAIT_STATES == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                dataMemorySuccess = 1'b0;
                if (int'(count) == WAIT_STATES - 1) begin
                    state_next = DONE;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            dataMemorySuccess = 1'b1;
        end
    end

    // State register, request latch and registered load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            count             <= '0;
            dataMemoryDataOut <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state == IDLE && request) begin
                req_index    <= dataMemoryAddress[ADDRESS_WIDTH+1:2];
                req_offset   <= dataMemoryAddress[1:0];
                req_data     <= dataMemoryDataIn;
                req_write    <= dataMemoryWriteEnable;
                req_byte     <= dataMemoryReadByte;
                req_half     <= dataMemoryReadHalf;
                req_unsigned <= dataMemoryReadUnsigned;
            end
            if (entering_done && !sel_write) begin
                dataMemoryDataOut <= load_value;
            end
        end
    end

    // Stores commit at the clock edge that ends DONE, so a reset asserted
    // during DONE cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && state == DONE && req_write) begin
            mem[req_index] <= req_data;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//
// Self-checking bench for data_memory_responder. A WAIT_STATES=2 instance
// is exercised with a table of directed loads/stores, hand-written reset
// and back-to-back sequences, and randomized transactions compared against
// a word-array reference model. A second instance with WAIT_STATES=0
// covers the single-cycle handshake.
module tb_data_memory_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic        re  = 1'b0;
    logic        rb  = 1'b0;
    logic        rh  = 1'b0;
    logic        ru  = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din  = '0;
    logic [31:0] dout;
    logic        success;

    logic        z_we  = 1'b0;
    logic        z_re  = 1'b0;
    logic [31:0] z_addr = '0;
    logic [31:0] z_din  = '0;
    logic [31:0] z_dout;
    logic        z_success;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_mem [1024];
    logic [31:0] model_out;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] din;
        logic        rb;
        logic        rh;
        logic        ru;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[$];

    data_memory_responder #(.ADDRESS_WIDTH(10), .WAIT_STATES(WS)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .dataMemoryWriteEnable  (we),
        .dataMemoryReadEnable   (re),
        .dataMemoryAddress      (addr),
        .dataMemoryDataIn       (din),
        .dataMemoryReadByte     (rb),
        .dataMemoryReadHalf     (rh),
        .dataMemoryReadUnsigned (ru),
        .dataMemoryDataOut      (dout),
        .dataMemorySuccess      (success)
    );

    data_memory_responder #(.ADDRESS_WIDTH(10), .WAIT_STATES(0)) dut_zero (
        .clk                    (clk),
        .rst                    (rst),
        .dataMemoryWriteEnable  (z_we),
        .dataMemoryReadEnable   (z_re),
        .dataMemoryAddress      (z_addr),
        .dataMemoryDataIn       (z_din),
        .dataMemoryReadByte     (1'b0),
        .dataMemoryReadHalf     (1'b0),
        .dataMemoryReadUnsigned (1'b0),
        .dataMemoryDataOut      (z_dout),
        .dataMemorySuccess      (z_success)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference load: pick the lane by shifting the word, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic b, input logic h, input logic u);
        int          width;
        int          shift;
        logic [31:0] mask;
        logic [31:0] value;
        if (b) begin
            width = 8;
            shift = 8 * int'(off);
        end else if (h) begin
            width = 16;
            shift = 16 * int'(off[1]);
        end else begin
            return word;
        end
        mask  = (32'h1 << width) - 32'h1;
        value = (word >> shift) & mask;
        if (!u && value[width-1]) value = value | ~mask;
        return value;
    endfunction

    function automatic void model_apply(input logic w, input logic r, input logic [31:0] a,
                                        input logic [31:0] d, input logic b, input logic h, input logic u);
        int index;
        index = int'((a >> 2) % 1024);
        if (w) model_mem[index] = d;
        else if (r) model_out = model_load(model_mem[index], a[1:0], b, h, u);
    endfunction

    function automatic void add_vec(input string name, input logic w, input logic r, input logic [31:0] a,
                                    input logic [31:0] d, input logic b, input logic h, input logic u,
                                    input logic [31:0] expected);
        vec_t v;
        v.name = name; v.we = w; v.re = r; v.addr = a; v.din = d;
        v.rb = b; v.rh = h; v.ru = u; v.expected = expected;
        vecs.push_back(v);
    endfunction

    // One full transaction starting just after a rising edge. Success is
    // sampled mid-cycle for WS+2 cycles and must be low until the last one;
    // the data output is captured during the DONE cycle.
    task automatic applyStimulus(input string name, input logic w, input logic r, input logic [31:0] a,
                                 input logic [31:0] d, input logic b, input logic h, input logic u,
                                 output logic [31:0] got);
        logic [31:0] pattern;
        we = w; re = r; addr = a; din = d; rb = b; rh = h; ru = u;
        pattern = '0;
        got     = '0;
        for (int k = 0; k < WS + 2; k++) begin
            @(negedge clk);
            pattern[k] = success;
            if (k == WS + 1) got = dout;
            @(posedge clk); #1;
        end
        we = 1'b0; re = 1'b0;
        model_apply(w, r, a, d, b, h, u);
        checkOutput({name, " success"}, pattern, 32'h1 << (WS + 1));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] pattern;
        logic [31:0] a;
        int          kind;

        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        model_out = '0;

        add_vec("store DEADBEEF",   1, 0, 32'h10,   32'hDEADBEEF, 0, 0, 0, 32'h0000_0000);
        add_vec("word 0x10",        0, 1, 32'h10,   32'h0,        0, 0, 0, 32'hDEADBEEF);
        add_vec("byte 0x13 s",      0, 1, 32'h13,   32'h0,        1, 0, 0, 32'hFFFF_FFDE);
        add_vec("byte 0x13 u",      0, 1, 32'h13,   32'h0,        1, 0, 1, 32'h0000_00DE);
        add_vec("byte 0x11 s",      0, 1, 32'h11,   32'h0,        1, 0, 0, 32'hFFFF_FFBE);
        add_vec("byte 0x10 s",      0, 1, 32'h10,   32'h0,        1, 0, 0, 32'hFFFF_FFEF);
        add_vec("half 0x12 s",      0, 1, 32'h12,   32'h0,        0, 1, 0, 32'hFFFF_DEAD);
        add_vec("half 0x10 u",      0, 1, 32'h10,   32'h0,        0, 1, 1, 32'h0000_BEEF);
        add_vec("half 0x11 u",      0, 1, 32'h11,   32'h0,        0, 1, 1, 32'h0000_BEEF);
        add_vec("byte+half 0x12 u", 0, 1, 32'h12,   32'h0,        1, 1, 1, 32'h0000_00AD);
        add_vec("word unsigned",    0, 1, 32'h10,   32'h0,        0, 0, 1, 32'hDEADBEEF);
        add_vec("store alias",      1, 0, 32'h1010, 32'hCAFEF00D, 0, 0, 0, 32'hDEADBEEF);
        add_vec("load alias",       0, 1, 32'h10,   32'h0,        0, 0, 0, 32'hCAFEF00D);
        add_vec("read+write",       1, 1, 32'h10,   32'h1,        0, 0, 0, 32'hCAFEF00D);
        add_vec("load after r+w",   0, 1, 32'h10,   32'h0,        0, 0, 0, 32'h0000_0001);

        // Reset held for two cycles with a load request present.
        rst = 1'b1; re = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset success", {31'h0, success}, 32'h1);
            checkOutput("reset data", dout, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        applyStimulus("post-reset load", 0, 1, 32'h10, 32'h0, 0, 0, 0, got);

        // Give the words used below a known value before relying on them.
        applyStimulus("store 0 @0x20", 1, 0, 32'h20, 32'h0, 0, 0, 0, got);
        applyStimulus("load 0x20", 0, 1, 32'h20, 32'h0, 0, 0, 0, got);
        checkOutput("load 0x20 data", got, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din,
                          vecs[i].rb, vecs[i].rh, vecs[i].ru, got);
            checkOutput({vecs[i].name, " data"}, got, vecs[i].expected);
        end

        // Read held high for eight cycles: two back-to-back transactions.
        we = 1'b0; re = 1'b1; addr = 32'h10; rb = 1'b0; rh = 1'b0; ru = 1'b0;
        pattern = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pattern[k] = success;
            if (k == 3 || k == 7) checkOutput("b2b data", dout, 32'h0000_0001);
            @(posedge clk); #1;
        end
        re = 1'b0;
        checkOutput("b2b success", pattern, 32'h0000_0088);

        // Reset during WAIT discards the store.
        we = 1'b1; addr = 32'h20; din = 32'h12345678;
        @(negedge clk);
        checkOutput("rst-wait accept", {31'h0, success}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst-wait success", {31'h0, success}, 32'h1);
        checkOutput("rst-wait data", dout, 32'h0);
        @(posedge clk); #1;
        model_out = '0;
        applyStimulus("load after rst-wait", 0, 1, 32'h20, 32'h0, 0, 0, 0, got);
        checkOutput("load after rst-wait data", got, 32'h0);

        // Reset during DONE also cancels the write.
        applyStimulus("store 0x24", 1, 0, 32'h24, 32'h11111111, 0, 0, 0, got);
        we = 1'b1; addr = 32'h24; din = 32'h22222222;
        for (int k = 0; k < WS + 1; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0;
        model_out = '0;
        applyStimulus("load after rst-done", 0, 1, 32'h24, 32'h0, 0, 0, 0, got);
        checkOutput("load after rst-done data", got, 32'h11111111);

        // Randomized traffic over a 16-word pool with random alias bits.
        for (int i = 0; i < 16; i++) begin
            a = {$urandom_range(0, 1048575), 10'(10'h40 + i), 2'($urandom_range(0, 3))};
            applyStimulus("pool init", 1, 0, a, $urandom, 0, 0, 0, got);
        end
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a = {$urandom_range(0, 1048575), 10'(10'h40 + $urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            applyStimulus("random", (kind == 0 || kind == 3), (kind != 0), a, $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
            checkOutput("random data", got, model_out);
        end

        // Zero wait states: success low for exactly one cycle per request.
        z_we = 1'b1; z_addr = 32'h8; z_din = 32'hA5A55A5A;
        @(negedge clk);
        checkOutput("ws0 store accept", {31'h0, z_success}, 32'h0);
        @(posedge clk); #1;
        z_we = 1'b0;
        @(negedge clk);
        checkOutput("ws0 store done", {31'h0, z_success}, 32'h1);
        @(posedge clk); #1;
        z_re = 1'b1;
        @(negedge clk);
        checkOutput("ws0 load accept", {31'h0, z_success}, 32'h0);
        @(posedge clk); #1;
        z_re = 1'b0;
        @(negedge clk);
        checkOutput("ws0 load done", {31'h0, z_success}, 32'h1);
        checkOutput("ws0 load data", z_dout, 32'hA5A55A5A);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("ws0 idle", {31'h0, z_success}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
